zoom_fifo_unpack: RTL and testbench
===================================

ZOOM_FIFO_UNPACK -- requirements
Module: zoom_fifo_unpack

Interface
REQ-001 Parameter DATA_WIDTH, default 240: width of one zoom FIFO word.
REQ-002 Parameter PIX_WIDTH, default 24: width of one RGB888 pixel; DATA_WIDTH SHALL be an integer multiple of PIX_WIDTH (PIX_PER_WORD = 10).
REQ-003 Parameter RD_LATENCY, default 2: cycles from an accepted fifo_rd_en to valid fifo_rd_data (FIFO built with output register).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  level; 1 = stream pixels, 0 = stop at the next word boundary.
REQ-007 cfg_line_words  input  8  FIFO words per video line; 0 is illegal and SHALL be treated as 1.
REQ-008 fifo_rd_en  output  1  read strobe to the sync zoom FIFO.
REQ-009 fifo_rd_data  input  DATA_WIDTH  read data from the FIFO.
REQ-010 fifo_empty  input  1  FIFO empty flag.
REQ-011 pix_data  output  PIX_WIDTH  pixel output; pixel 0 = fifo_rd_data[23:0] (LSB first).
REQ-012 pix_valid  output  1  pix_data is valid.
REQ-013 pix_ready  input  1  downstream accepts when pix_valid && pix_ready.
REQ-014 pix_eol  output  1  qualifies the last pixel of a line (with pix_valid).
REQ-015 busy  output  1  FSM not in IDLE.

Function
REQ-016 FSM states IDLE, PRIME, STREAM, DRAIN; reset state IDLE.
REQ-017 IDLE -> PRIME when enable=1; PRIME -> STREAM when the word buffer holds >=1 word; STREAM -> DRAIN when enable=0; DRAIN -> IDLE when the current word is fully sent and no read is in flight.
REQ-018 The word buffer SHALL have 2 entries; fifo_rd_en SHALL assert only in PRIME/STREAM, when fifo_empty=0 and (buffered words + reads in flight) < 2.
REQ-019 Reads in flight SHALL be tracked by a RD_LATENCY-deep valid shift register; returning data SHALL be written into the buffer exactly RD_LATENCY cycles after the strobe.
REQ-020 The buffer SHALL never overflow; a read returning while the buffer is full is a design error that cannot occur under REQ-018.
REQ-021 pix_valid SHALL be high whenever the head word holds unsent pixels in STREAM or DRAIN; pix_data = head[idx*PIX_WIDTH +: PIX_WIDTH], idx 0..PIX_PER_WORD-1.
REQ-022 On a handshake idx increments; at idx = PIX_PER_WORD-1 idx wraps to 0 and the head word pops in the same cycle.
REQ-023 pix_data/pix_valid SHALL stay stable while pix_valid && !pix_ready.
REQ-024 Sustained throughput SHALL be one pixel per clock when pix_ready=1 and the FIFO is not empty.
REQ-025 A word counter SHALL count popped words; pix_eol = 1 on the last pixel of word cfg_line_words-1; counter wraps to 0 after that pop.
REQ-026 Simultaneous buffer push and pop in one cycle SHALL keep the occupancy unchanged.
REQ-027 In DRAIN, words still buffered beyond the current one SHALL be sent before IDLE; no new reads issue.
REQ-028 fifo_empty asserting mid-line SHALL only stall pix_valid; no data is lost or duplicated.

Reset
REQ-029 On rst_n=0: fifo_rd_en=0, pix_valid=0, pix_eol=0, pix_data=0, busy=0, idx=0, word counter=0, buffer empty, in-flight register cleared, state IDLE.
REQ-030 Reset asserted mid-operation SHALL discard buffered and in-flight data; first pixel after release comes from a fresh FIFO read.

Configuration
REQ-031 Macro ZOOM_UNPACK_UNDERRUN_CNT_EN: when defined, adds output underrun_cnt (16 bits), incrementing (saturating at 0xFFFF) each STREAM cycle with pix_ready=1 and pix_valid=0, cleared by reset; when undefined the port and counter are absent.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, PIX_PER_WORD derivation and the default widths.
REQ-033 One sub-module, zoom_unpack_wbuf (2-entry word buffer with push/pop/count), SHALL be instantiated.

Verification
REQ-034 Preload 16 words (word n holds pixels 10n..10n+9), enable=1, pix_ready=1 -> 160 pixels 0..159 in order, one per clock after the first.
REQ-035 cfg_line_words=3, 6 words -> pix_eol high on pixels 29 and 59 only.
REQ-036 pix_ready toggles 1010... -> no lost or duplicated pixels, pix_data stable while stalled.
REQ-037 FIFO empty after 2 words, refill after 20 cycles -> pix_valid gaps only, sequence continuous, fifo_rd_en never high while fifo_empty=1.
REQ-038 enable dropped at pixel 13 -> pixels through 19 plus any buffered word sent, then busy=0, no further fifo_rd_en.
REQ-039 rst_n pulsed low at pixel 25 -> all outputs 0 within the same cycle; after release the first pixel equals pixel 0 of the next FIFO word.

Source files
------------

// File: rtl/zoom_fifo_unpack_pkg.sv
// Shared definitions for the zoom FIFO unpacker.
// Holds the default widths, the FSM state type and the pixels-per-word derivation.
package zoom_fifo_unpack_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 240;
    localparam int unsigned PIX_WIDTH_DEF  = 24;
    localparam int unsigned RD_LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream,
        StDrain
    } state_e;

    function automatic int unsigned pix_per_word(input int unsigned data_width,
                                                 input int unsigned pix_width);
        return data_width / pix_width;
    endfunction

endpackage

// File: rtl/zoom_unpack_wbuf.sv
// Two-entry word buffer between the zoom FIFO read port and the pixel serialiser.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data into the tail entry
//   push_data   word returning from the FIFO
//   pop         retire the head entry
//   head        oldest buffered word
//   count       number of buffered words (0..2)
// Push and pop in the same cycle leave count unchanged. The caller never pushes
// when full nor pops when empty.
module zoom_unpack_wbuf #(
    parameter int unsigned DATA_WIDTH = 240
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/zoom_fifo_unpack.sv
// Zoom FIFO unpacker: reads wide words from a synchronous FIFO (fixed read latency)
// and streams them out LSB-first as PIX_WIDTH pixels with a valid/ready handshake.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          1 = stream, 0 = finish buffered words then go idle
//   cfg_line_words  FIFO words per line (0 behaves as 1)
//   fifo_rd_en      read strobe to the FIFO
//   fifo_rd_data    FIFO read data, valid RD_LATENCY cycles after the strobe
//   fifo_empty      FIFO empty flag
//   pix_data        current pixel
//   pix_valid       pix_data valid
//   pix_ready       downstream ready
//   pix_eol         last pixel of a line (qualified by pix_valid)
//   busy            FSM not idle
//   underrun_cnt    (only with ZOOM_UNPACK_UNDERRUN_CNT_EN) saturating count of STREAM
//                   cycles where downstream was ready but no pixel was available
module zoom_fifo_unpack
    import zoom_fifo_unpack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [7:0]            cfg_line_words,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [PIX_WIDTH-1:0]  pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_eol,
    output logic                  busy
`ifdef ZOOM_UNPACK_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    localparam int unsigned PIX_PER_WORD = pix_per_word(DATA_WIDTH, PIX_WIDTH);
    localparam int unsigned IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [7:0]            word_cnt_q;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] wb_head;
    logic [1:0]            wb_count;
    logic                  wb_push, wb_pop;
    logic                  hs, last_pix, last_word;
    logic [7:0]            line_words;
    int unsigned           pending;
    int unsigned           pix_sel;

    zoom_unpack_wbuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wb_push),
        .push_data(fifo_rd_data),
        .pop      (wb_pop),
        .head     (wb_head),
        .count    (wb_count)
    );

    // Returning data lands exactly when the strobe reaches the end of the shift register.
    assign wb_push = inflight_q[RD_LATENCY-1];

    assign line_words = (cfg_line_words == 8'd0) ? 8'd1 : cfg_line_words;
    assign last_word  = word_cnt_q >= (line_words - 8'd1);
    assign last_pix   = idx_q == LAST_IDX;
    assign hs         = pix_valid && pix_ready;
    assign wb_pop     = hs && last_pix;
    assign pix_sel    = 32'(idx_q) * PIX_WIDTH;

    // Buffered plus in-flight words; reads are throttled so this never exceeds the
    // two buffer entries, which is what keeps the buffer from overflowing.
    always_comb begin
        pending = 32'(wb_count);
        for (int i = 0; i < RD_LATENCY; i++) begin
            pending = pending + 32'(inflight_q[i]);
        end
    end

    always_comb begin
        inflight_d    = inflight_q << 1;
        inflight_d[0] = fifo_rd_en;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enable) state_d = StPrime;
            StPrime: begin
                if (!enable) begin
                    state_d = StDrain;
                end else if (wb_count != 2'd0) begin
                    state_d = StStream;
                end
            end
            StStream: if (!enable) state_d = StDrain;
            StDrain: begin
                if (wb_count == 2'd0 && inflight_q == '0) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = state_q != StIdle;
        fifo_rd_en = (state_q == StPrime || state_q == StStream) && !fifo_empty
                     && (pending < 2);
        pix_valid  = (state_q == StStream || state_q == StDrain) && (wb_count != 2'd0);
        pix_eol    = pix_valid && last_pix && last_word;
        pix_data   = pix_valid ? wb_head[pix_sel +: PIX_WIDTH] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            word_cnt_q <= 8'd0;
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (hs) begin
                idx_q <= last_pix ? '0 : idx_q + IDX_W'(1);
            end
            if (wb_pop) begin
                word_cnt_q <= last_word ? 8'd0 : word_cnt_q + 8'd1;
            end
        end
    end

`ifdef ZOOM_UNPACK_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 16'd0;
        end else if (state_q == StStream && pix_ready && !pix_valid
                     && underrun_q != 16'hFFFF) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_zoom_fifo_unpack.sv
// Self-checking bench for zoom_fifo_unpack. A queue models the FIFO contents;
// every accepted read appends its ten pixels to an expected-pixel scoreboard,
// and one sampling process compares the DUT pixel stream against it each cycle.
module tb_zoom_fifo_unpack;

    localparam int DW  = 240;
    localparam int PW  = 24;
    localparam int PPW = 10;
    localparam int LAT = 2;

    logic          clk_tb = 1'b0;
    logic          tb_rst = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    cfg_line_words = 8'd1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty = 1'b1;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          pix_eol;
    logic          busy;

    logic [DW-1:0] pipe [LAT];
    logic [DW-1:0] fifo_q [$];
    logic [PW-1:0] sb [$];
    logic [PW-1:0] hs_log [$];
    logic [PW-1:0] eol_vals [$];

    int            checks = 0;
    int            errors = 0;
    int            pix_cnt = 0;
    int            n_reads = 0;
    int            cycle = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    int            seq = 0;
    logic          fire = 1'b0;
    logic [DW-1:0] fire_word = '0;
    logic          stall_prev = 1'b0;
    logic [PW-1:0] stall_data = '0;
    logic          en_prev = 1'b0;

    assign fifo_rd_data = pipe[LAT-1];

    always #5 clk_tb = ~clk_tb;

    zoom_fifo_unpack #(
        .DATA_WIDTH(DW),
        .PIX_WIDTH (PW),
        .RD_LATENCY(LAT)
    ) dut (
        .clk           (clk_tb),
        .rst_n         (tb_rst),
        .enable        (enable),
        .cfg_line_words(cfg_line_words),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_eol       (pix_eol),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[DW-33:0], 32'($urandom())};
        return w;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Synchronous FIFO with output register: data appears LAT cycles after the strobe.
    // Garbage is shifted in on idle cycles so mistimed captures are visible.
    always @(posedge clk_tb) begin
        pipe[0] <= fire ? fire_word : rand_word();
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Sample 1 time unit before each rising edge; inputs change on the falling edge.
    always @(negedge clk_tb) begin
        int lw;
        logic [PW-1:0] exp_pix;
        #4;
        cycle++;
        if (!tb_rst) begin
            chk("reset_outputs", longint'({fifo_rd_en, pix_valid, pix_eol, busy, pix_data}), 0);
            sb.delete();
            pix_cnt    = 0;
            fire       = 1'b0;
            stall_prev = 1'b0;
            en_prev    = enable;
        end else begin
            lw   = (cfg_line_words == 8'd0) ? 1 : int'(cfg_line_words);
            fire = fifo_rd_en;
            if (fifo_rd_en) begin
                chk("rd_en_while_empty", longint'(fifo_empty), 0);
                chk("rd_en_after_disable", longint'(!enable && !en_prev), 0);
                chk("rd_en_needs_busy", longint'(busy), 1);
                if (fifo_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_underflow: got read with 0 words, expected no read");
                    fire = 1'b0;
                end else begin
                    fire_word = fifo_q.pop_front();
                    n_reads++;
                    for (int k = 0; k < PPW; k++) sb.push_back(fire_word[k*PW +: PW]);
                end
            end
            if (stall_prev) begin
                chk("stall_valid", longint'(pix_valid), 1);
                chk("stall_data", longint'(pix_data), longint'(stall_data));
            end
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %0d, expected none", pix_data);
                end else begin
                    chk("pix_data", longint'(pix_data), longint'(sb[0]));
                    chk("pix_eol", longint'(pix_eol),
                        longint'((pix_cnt % (lw * PPW)) == (lw * PPW - 1)));
                    if (pix_ready) begin
                        exp_pix = sb.pop_front();
                        if (hs_log.size() == 0) first_cyc = cycle;
                        last_cyc = cycle;
                        hs_log.push_back(pix_data);
                        if (pix_eol) eol_vals.push_back(pix_data);
                        pix_cnt++;
                    end
                end
            end else begin
                chk("eol_without_valid", longint'(pix_eol), 0);
            end
            stall_prev = pix_valid && !pix_ready;
            stall_data = pix_data;
            en_prev    = enable;
        end
    end

    // mode 0: hold pix_ready, 1: toggle every cycle, 2: random (75% ready)
    task automatic tick(input int mode);
        @(negedge clk_tb);
        case (mode)
            1: pix_ready = ~pix_ready;
            2: pix_ready = ($urandom_range(3) != 0);
            default: ;
        endcase
    endtask

    task automatic wait_pix(input int target, input int mode, input int budget, input string name);
        int n = 0;
        while (pix_cnt < target && n < budget) begin
            tick(mode);
            n++;
        end
        if (pix_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got %0d pixels, expected %0d", name, pix_cnt, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        tick(0);
        while (busy && n < budget) begin
            tick(0);
            n++;
        end
        chk({"idle_", name}, longint'(busy), 0);
    endtask

    task automatic push_seq(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < PPW; k++) begin
                w[k*PW +: PW] = PW'(seq);
                seq++;
            end
            fifo_q.push_back(w);
        end
    endtask

    task automatic do_reset(input logic [7:0] cfg);
        @(negedge clk_tb);
        tb_rst         = 1'b0;
        enable         = 1'b0;
        pix_ready      = 1'b0;
        cfg_line_words = cfg;
        fifo_q.delete();
        seq = 0;
        repeat (3) @(negedge clk_tb);
        tb_rst = 1'b1;
        hs_log.delete();
        eol_vals.delete();
        n_reads = 0;
    endtask

    initial begin
        logic [PW-1:0] exp_first;
        int n;

        // Full-rate streaming of 16 preloaded words
        do_reset(8'd16);
        push_seq(16);
        repeat (2) @(negedge clk_tb);
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_pix(160, 0, 400, "stream");
        chk("stream_count", hs_log.size(), 160);
        if (hs_log.size() == 160) begin
            chk("stream_first", longint'(hs_log[0]), 0);
            chk("stream_last", longint'(hs_log[159]), 159);
        end
        chk("stream_rate", last_cyc - first_cyc, 159);
        chk("stream_eol_count", eol_vals.size(), 1);
        enable = 1'b0;
        wait_idle(50, "stream");

        // End-of-line marking with 3 words per line
        do_reset(8'd3);
        push_seq(6);
        repeat (2) @(negedge clk_tb);
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_pix(60, 0, 200, "eol");
        chk("eol_count", eol_vals.size(), 2);
        if (eol_vals.size() == 2) begin
            chk("eol_first", longint'(eol_vals[0]), 29);
            chk("eol_second", longint'(eol_vals[1]), 59);
        end
        enable = 1'b0;
        wait_idle(50, "eol");

        // Alternating backpressure
        do_reset(8'd4);
        push_seq(8);
        repeat (2) @(negedge clk_tb);
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_pix(80, 1, 400, "toggle");
        chk("toggle_count", hs_log.size(), 80);
        if (hs_log.size() == 80) chk("toggle_last", longint'(hs_log[79]), 79);
        enable = 1'b0;
        wait_idle(50, "toggle");

        // FIFO runs dry after two words and refills later
        do_reset(8'd8);
        push_seq(2);
        repeat (2) @(negedge clk_tb);
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_pix(20, 0, 100, "underrun_a");
        repeat (20) tick(0);
        chk("underrun_stalled", pix_cnt, 20);
        push_seq(6);
        wait_pix(80, 0, 300, "underrun_b");
        chk("underrun_count", hs_log.size(), 80);
        if (hs_log.size() == 80) chk("underrun_mid", longint'(hs_log[20]), 20);
        enable = 1'b0;
        wait_idle(50, "underrun");

        // Disable mid-word: finish buffered words, then stop reading
        do_reset(8'd5);
        push_seq(10);
        repeat (2) @(negedge clk_tb);
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_pix(13, 0, 100, "drain");
        enable = 1'b0;
        wait_idle(100, "drain");
        n = pix_cnt;
        chk("drain_word_boundary", longint'(n % PPW == 0 && n >= 20 && n <= 30), 1);
        chk("drain_all_sent", sb.size(), 0);
        chk("drain_reads_match", n_reads * PPW, n);
        repeat (20) tick(0);
        chk("drain_no_more_pixels", pix_cnt, n);

        // Asynchronous reset in mid-stream
        do_reset(8'd2);
        push_seq(12);
        repeat (2) @(negedge clk_tb);
        pix_ready = 1'b1;
        enable    = 1'b1;
        wait_pix(25, 0, 100, "midreset");
        #2;
        tb_rst = 1'b0;
        repeat (2) @(negedge clk_tb);
        tb_rst = 1'b1;
        exp_first = fifo_q[0][PW-1:0];
        hs_log.delete();
        wait_pix(10, 0, 100, "after_reset");
        if (hs_log.size() > 0) chk("after_reset_first", longint'(hs_log[0]), longint'(exp_first));
        enable = 1'b0;
        wait_idle(100, "after_reset");
        chk("after_reset_all_sent", sb.size(), 0);

        // Randomised traffic, first with cfg 0 (one word per line) then random line length
        for (int r = 0; r < 2; r++) begin
            do_reset((r == 0) ? 8'd0 : 8'($urandom_range(2, 5)));
            repeat (2) @(negedge clk_tb);
            enable = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(3) == 0 && fifo_q.size() < 8) fifo_q.push_back(rand_word());
                tick(2);
            end
            n = 0;
            while ((fifo_q.size() != 0 || sb.size() != 0) && n < 400) begin
                tick(2);
                n++;
            end
            chk("random_flushed", sb.size() + fifo_q.size(), 0);
            enable    = 1'b0;
            pix_ready = 1'b1;
            wait_idle(100, "random");
            chk("random_reads_match", n_reads * PPW, pix_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
